// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared operation encoding and limits for the alu_pipe datapath
package alu_pipe_pkg;

    localparam int MAX_STAGES = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_e;

endpackage

// File: rtl/alu_pipe_alu_comb.sv
// rtl/alu_pipe_alu_comb.sv - combinational two-operand ALU with zero/negative flags
module alu_comb
    import alu_pipe_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    input  logic [1:0]        sel,
    output logic [DWIDTH-1:0] res,
    output logic              zero,
    output logic              neg
);

    alu_sel_e op;

    // add/sub wrap modulo 2^DWIDTH; flags describe the truncated result
    always_comb begin
        op = alu_sel_e'(sel);
        case (op)
            ALU_ADD: res = op1 + op2;
            ALU_SUB: res = op1 - op2;
            ALU_AND: res = op1 & op2;
            ALU_OR:  res = op1 | op2;
            default: res = '0;
        endcase
        zero = (res == '0);
        neg  = res[DWIDTH-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - elastic STAGES-deep ALU pipeline; ALU_PIPE_FLAGS_EN carries zero/neg flags
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int STAGES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DWIDTH-1:0]            op1_i,
    input  logic [DWIDTH-1:0]            op2_i,
    input  logic [1:0]                   sel_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DWIDTH-1:0]            res_o,
    output logic                         zero_o,
    output logic                         neg_o,
    output logic [$clog2(STAGES+1)-1:0] occupancy_o
);

    localparam int OCC_W = $clog2(STAGES+1);

    typedef struct packed {
        logic [DWIDTH-1:0] res;
`ifdef ALU_PIPE_FLAGS_EN
        logic              zero;
        logic              neg;
`endif
    } stage_t;

    logic [DWIDTH-1:0] alu_res;
    logic              alu_zero;
    logic              alu_neg;
    stage_t            alu_pay;

    stage_t            pay    [STAGES];
    stage_t            pay_in [STAGES];
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] shift_in;
    logic [STAGES:0]   down_ready;
    logic [OCC_W-1:0]  occ_next;
    logic [OCC_W-1:0]  occupancy_q;

    alu_comb #(.DWIDTH(DWIDTH)) u_alu (
        .op1  (op1_i),
        .op2  (op2_i),
        .sel  (sel_i),
        .res  (alu_res),
        .zero (alu_zero),
        .neg  (alu_neg)
    );

    always_comb begin
        alu_pay     = '0;
        alu_pay.res = alu_res;
`ifdef ALU_PIPE_FLAGS_EN
        alu_pay.zero = alu_zero;
        alu_pay.neg  = alu_neg;
`endif
    end

    // Ready ripples back from the consumer; a stage can load if empty or draining.
    always_comb begin
        adv                = '0;
        down_ready         = '0;
        down_ready[STAGES] = out_ready_i;
        for (int i = STAGES-1; i >= 0; i--) begin
            adv[i]        = valid[i] & down_ready[i+1];
            down_ready[i] = ~valid[i] | adv[i];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign shift_in[g] = in_valid_i;
            assign pay_in[g]   = alu_pay;
        end else begin : g_tail
            assign shift_in[g] = adv[g-1];
            assign pay_in[g]   = pay[g-1];
        end
        assign valid_next[g] = down_ready[g] ? shift_in[g] : valid[g];
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_next = occ_next + OCC_W'(valid_next[i]);
        end
    end

    // Payload only moves alongside a valid item; empty stages keep stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pay[i] <= '0;
            end
        end else begin
            valid       <= valid_next;
            occupancy_q <= occ_next;
            for (int i = 0; i < STAGES; i++) begin
                if (down_ready[i] && shift_in[i]) begin
                    pay[i] <= pay_in[i];
                end
            end
        end
    end

    assign in_ready_o  = down_ready[0];
    assign out_valid_o = valid[STAGES-1];
    assign res_o       = pay[STAGES-1].res;
    assign occupancy_o = occupancy_q;

`ifdef ALU_PIPE_FLAGS_EN
    assign zero_o = pay[STAGES-1].zero;
    assign neg_o  = pay[STAGES-1].neg;
`else
    logic unused_flags;
    assign unused_flags = alu_zero | alu_neg;
    assign zero_o       = 1'b0;
    assign neg_o        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized self-checking bench for alu_pipe against a queue model
module tb_alu_pipe;

    localparam int DWIDTH = 32;
    localparam int STAGES = 3;
    localparam int OCC_W  = $clog2(STAGES+1);
`ifdef ALU_PIPE_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] op1;
    logic [DWIDTH-1:0] op2;
    logic [1:0]        sel;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] res;
    logic              zero;
    logic              neg;
    logic [OCC_W-1:0]  occupancy;

    alu_pipe #(.DWIDTH(DWIDTH), .STAGES(STAGES)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op1_i       (op1),
        .op2_i       (op2),
        .sel_i       (sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .zero_o      (zero),
        .neg_o       (neg),
        .occupancy_o (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DWIDTH-1:0] res;
        bit                zero;
        bit                neg;
        int                acc;
    } item_t;

    item_t             q[$];
    logic [DWIDTH-1:0] dlog[$];
    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_dep = -1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DWIDTH-1:0] ref_alu(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b,
                                                  input logic [1:0] s);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model: items leave in order; the head is presentable STAGES cycles after
    // acceptance, but never before the cycle after its predecessor departed.
    always @(negedge clk) begin
        item_t it;
        int    head_rdy;
        bit    exp_ov;
        if (rst) begin
            q.delete();
            last_dep = -1000;
        end else begin
            exp_ov = 1'b0;
            if (q.size() > 0) begin
                head_rdy = q[0].acc + STAGES;
                if (last_dep + 1 > head_rdy) head_rdy = last_dep + 1;
                exp_ov = (cyc >= head_rdy);
            end
            chk("in_ready", in_ready, (q.size() < STAGES) || out_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("occupancy", occupancy, q.size());
            if (out_valid && q.size() > 0) begin
                chk("res", res, q[0].res);
                chk("zero", zero, q[0].zero);
                chk("neg", neg, q[0].neg);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                dlog.push_back(res);
                void'(q.pop_front());
                last_dep = cyc;
            end
            if (in_valid && in_ready) begin
                it.res  = ref_alu(op1, op2, sel);
                it.zero = FL && (it.res == '0);
                it.neg  = FL && it.res[DWIDTH-1];
                it.acc  = cyc;
                q.push_back(it);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic single(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b, input logic [1:0] s,
                          input logic [DWIDTH-1:0] er, input bit ez, input bit en, input string nm);
        int lat;
        out_ready = 1'b1;
        op1 = a;
        op2 = b;
        sel = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, lat, STAGES);
        chk({nm, "_res"}, res, er);
        chk({nm, "_zero"}, zero, ez & FL);
        chk({nm, "_neg"}, neg, en & FL);
        tick();
        chk({nm, "_occ_after"}, occupancy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        bit acc;

        rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; sel = 2'd0; out_ready = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_zero", zero, 0);
        chk("rst_neg", neg, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;

        single(32'd5, 32'd7, 2'd0, 32'd12, 1'b0, 1'b0, "add_5_7");
        single(32'd3, 32'd5, 2'd1, 32'hFFFF_FFFE, 1'b0, 1'b1, "sub_3_5");
        single(32'd9, 32'd9, 2'd1, 32'd0, 1'b1, 1'b0, "sub_9_9");
        single(32'd0, 32'd1, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, "sub_0_1");
        single(32'hF0F0_1234, 32'h0FF0_FFFF, 2'd2, 32'h00F0_1234, 1'b0, 1'b0, "and");
        single(32'h8000_0001, 32'h0000_0100, 2'd3, 32'h8000_0101, 1'b0, 1'b1, "or");

        // back-pressure: fill with the consumer stalled, then release
        dlog.delete();
        out_ready = 1'b0;
        n = 1;
        guard = 0;
        while (n <= 3 && guard < 20) begin
            op1 = n; op2 = 0; sel = 2'd0; in_valid = 1'b1;
            #1 acc = in_ready;
            tick();
            if (acc) n++;
            guard++;
        end
        op1 = n;
        #1;
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_occ_full", occupancy, STAGES);
        chk("bp_out_valid_full", out_valid, 1);
        repeat (3) tick();
        out_ready = 1'b1;
        guard = 0;
        while (n <= 10 && guard < 40) begin
            op1 = n; op2 = 0; sel = 2'd0; in_valid = 1'b1;
            #1 acc = in_ready;
            tick();
            if (acc) n++;
            guard++;
        end
        in_valid = 1'b0;
        repeat (STAGES + 3) tick();
        chk("bp_count", dlog.size(), 10);
        for (int k = 0; k < 10 && k < dlog.size(); k++) begin
            chk("bp_order", dlog[k], k + 1);
        end

        // sustained throughput
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            op1 = 100 + k; op2 = k; sel = 2'($urandom); in_valid = 1'b1;
            tick();
            chk("tp_occ", occupancy, (k + 1 < STAGES) ? k + 1 : STAGES);
            chk("tp_out_valid", out_valid, (k + 1 >= STAGES) ? 1 : 0);
        end
        in_valid = 1'b0;
        repeat (STAGES + 2) tick();

        // reset with two items in flight
        out_ready = 1'b0;
        op1 = 11; op2 = 22; sel = 2'd0; in_valid = 1'b1;
        tick();
        op1 = 33;
        tick();
        in_valid = 1'b0;
        tick();
        chk("midrst_pre_out_valid", out_valid, 1);
        chk("midrst_pre_occ", occupancy, 2);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_occ", occupancy, 0);
        chk("midrst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        single(32'd40, 32'd2, 2'd0, 32'd42, 1'b0, 1'b0, "post_rst");

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom % 3) != 0;
            out_ready = ($urandom % 4) != 0;
            op1 = $urandom;
            op2 = (($urandom % 8) == 0) ? op1 : $urandom;
            sel = 2'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 4) tick();
        chk("drained_occ", occupancy, 0);
        chk("drained_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, elastic successor to the fixed three-stage pipeline. It computes a 2-bit-selected ALU operation on two DWIDTH operands and carries the result and flags through STAGES register stages. Each stage has a valid bit, and a valid/ready handshake on both ends supports back-pressure. It sits between operand-producing logic and a consumer that may stall, and is the datapath template for later processor stages.

## Interface
- DWIDTH, 32, operand/result width (≥ 2)
- STAGES, 3, number of register stages (1..8); fixes latency
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid_i  in  1  operands and sel valid this cycle
- in_ready_o  out  1  pipeline can accept this cycle
- op1_i  in  DWIDTH  operand 1
- op2_i  in  DWIDTH  operand 2
- sel_i  in  2  operation: 00 add, 01 sub (op1−op2), 10 and, 11 or
- out_valid_o  out  1  result at last stage valid
- out_ready_i  in  1  consumer accepts this cycle
- res_o  out  DWIDTH  result
- zero_o  out  1  res == 0
- neg_o  out  1  res[DWIDTH-1]
- occupancy_o  out  $clog2(STAGES+1)  number of valid stages

## Operation
- ALU is combinational on the inputs and registered into stage 0 on acceptance. Stages 1..STAGES-1 are pure delay registers holding {res, zero, neg} and valid.
- Add/sub are modulo 2^DWIDTH; carry-out is discarded. zero/neg are derived from the truncated result.
- Stage i advances when valid[i] and (i is the last stage ? out_ready_i : stage i+1 can load).
- Stage i+1 can load when !valid[i+1] or stage i+1 advances. Bubbles are collapsed.
- in_ready_o = !valid[0] | stage 0 advances. The ready chain is combinational from out_ready_i; there is no combinational path from in_valid_i to in_ready_o.
- Acceptance is in_valid_i & in_ready_o. Output handshake is out_valid_o & out_ready_i.
- Data registers load only on a valid shift. Payload of invalid stages is don't-care and must not be checked.
- occupancy_o is the popcount of the valid bits. It is registered and updated in the same edge as the stages.
- Reset: all valid bits 0, data registers 0. Result: out_valid_o=0, res_o=0, zero_o=0, neg_o=0, occupancy_o=0, in_ready_o=1.
- Reset asserted mid-operation discards all in-flight items immediately and asynchronously. Nothing is replayed.
- Simultaneous output and input handshakes while full: throughput stays 1/cycle and occupancy is unchanged.
- out_valid_o and its payload must stay stable while out_valid_o & !out_ready_i.

## Timing
- Latency: an item accepted in cycle n is at the output in cycle n+STAGES if there is no stall.
- Throughput: 1 item/cycle sustained with out_ready_i held high.
- Capacity: STAGES items. When full with out_ready_i=0, in_ready_o=0 in the same cycle.
- A stall of k cycles at the output delays all queued items by k cycles. No item is lost or duplicated.
- STAGES=1: a single register; in_ready_o = !out_valid_o | out_ready_i.

## Configuration
- ALU_PIPE_FLAGS_EN defined: zero/neg are computed in stage 0 and carried through every stage.
- ALU_PIPE_FLAGS_EN undefined: no flag registers; zero_o and neg_o are tied to 0. Ports remain present.

## Structure
- Shared package alu_pipe_pkg:
  - alu_sel_e enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR)
  - stage payload struct typedef parametrised by DWIDTH via the module localparam
  - MAX_STAGES=8 constant
- One sub-module, alu_comb: purely combinational op/sel to result and flags, reused by later datapath stages.
- Stages are built from a generate loop over a payload array plus a valid vector.

## Test plan
- Reset, then add 5+7 with out_ready_i=1 and STAGES=3:
  - accepted cycle 0; out_valid_o in cycle 3
  - res_o=12, zero_o=0, neg_o=0
  - occupancy_o returns to 0
- Sub 3−5, DWIDTH=32: res_o=0xFFFFFFFE, neg_o=1. Sub 9−9: res_o=0, zero_o=1.
- Back-pressure, STAGES=3:
  - stream 1..10 (op1=i, op2=0, add) with out_ready_i=0 until full
  - in_ready_o falls after 3 accepts; occupancy_o=3
  - release: results 1..10 appear in order, no gaps or duplicates
- Full-throughput: in_valid_i and out_ready_i held at 1 for 20 items. One result per cycle after the first 3; occupancy_o constant at 3.
- Assert rst for one cycle with 2 items in flight:
  - out_valid_o=0 and occupancy_o=0 immediately, before the next clock edge
  - the next accepted item emerges alone after STAGES cycles
- Build without ALU_PIPE_FLAGS_EN, sub 0−1: res_o=0xFFFFFFFF, neg_o=0, zero_o=0.
